// File: rtl/hub_pkg.sv
// Shared types and widths for the nonce hub: FSM state encoding, word widths
// and the golden_id width helper.
package hub_pkg;

  localparam int NONCE_W = 32;
  localparam int DROP_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } hub_state_t;

  // A single source still needs a 1-bit id port.
  function automatic int id_width(input int slaves);
    return (slaves <= 1) ? 1 : $clog2(slaves);
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Per-source 32-bit synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
module nonce_fifo
  import hub_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [NONCE_W-1:0] din,
  output logic [NONCE_W-1:0] head,
  output logic               empty,
  output logic               full,
  output logic               empty_next
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [NONCE_W-1:0] mem [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // A pop frees the slot the same edge, so a push into a full FIFO is still taken.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign wr_ptr_next = wr_ptr + PTR_W'(do_push);
  assign rd_ptr_next = rd_ptr + PTR_W'(do_pop);
  assign empty_next  = (wr_ptr_next == rd_ptr_next);

  assign head = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end
  end

endmodule

// File: rtl/nonce_hub_arbiter.sv
// Collects golden nonces from several sources into per-source FIFOs and feeds
// them round-robin to the 32-bit serial word transmitter.
module nonce_hub_arbiter
  import hub_pkg::*;
#(
  parameter int  SLAVES       = 4,
  parameter int  DEPTH_LOG2   = 2,
  parameter int  BUSY_TIMEOUT = 15,
  localparam int ID_W         = id_width(SLAVES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
  input  logic [SLAVES-1:0]         new_nonces,
  input  logic                      serial_busy,
  output logic                      serial_send,
  output logic [NONCE_W-1:0]        golden_nonce,
  output logic [ID_W-1:0]           golden_id,
  output logic [SLAVES-1:0]         overflow,
  output logic [DROP_W-1:0]         drop_count,
  output logic                      pending
);

  localparam int CTR_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam int CNT_W = $clog2(SLAVES + 1);
  localparam int SUM_W = DROP_W + CNT_W;

  hub_state_t         state;
  hub_state_t         state_next;
  logic [SLAVES-1:0]  fifo_empty;
  logic [SLAVES-1:0]  fifo_full;
  logic [SLAVES-1:0]  fifo_empty_next;
  logic [SLAVES-1:0]  push_vec;
  logic [SLAVES-1:0]  pop_vec;
  logic [SLAVES-1:0]  drop_vec;
  logic [NONCE_W-1:0] fifo_head [SLAVES];
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_next;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    grant_q;
  logic               grant_valid;
  logic [CTR_W-1:0]   ctr;
  logic [CNT_W-1:0]   drop_inc;
  logic [SUM_W-1:0]   drop_sum;
  logic [DROP_W-1:0]  drop_count_next;

  for (genvar g = 0; g < SLAVES; g++) begin : g_fifo
    assign pop_vec[g]  = (state == LOAD) && (grant_q == ID_W'(g));
    assign drop_vec[g] = new_nonces[g] & fifo_full[g] & ~pop_vec[g];
    assign push_vec[g] = new_nonces[g] & ~drop_vec[g];

    nonce_fifo #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_vec[g]),
      .pop        (pop_vec[g]),
      .din        (slave_nonces[g*NONCE_W +: NONCE_W]),
      .head       (fifo_head[g]),
      .empty      (fifo_empty[g]),
      .full       (fifo_full[g]),
      .empty_next (fifo_empty_next[g])
    );
  end

  // First non-empty FIFO at or after rr_ptr, wrapping past the last source.
  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < SLAVES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= SLAVES) begin
        idx = idx - SLAVES;
      end
      if (!grant_valid && !fifo_empty[ID_W'(idx)]) begin
        grant_valid = 1'b1;
        grant       = ID_W'(idx);
      end
    end
    rr_next = (grant == ID_W'(SLAVES - 1)) ? '0 : grant + ID_W'(1);
  end

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < SLAVES; i++) begin
      drop_inc = drop_inc + CNT_W'(drop_vec[i]);
    end
    drop_sum        = SUM_W'(drop_count) + SUM_W'(drop_inc);
    drop_count_next = (drop_sum[SUM_W-1:DROP_W] != '0) ? '1 : drop_sum[DROP_W-1:0];
  end

  always_comb begin
    state_next  = state;
    serial_send = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid && !serial_busy) begin
          state_next = LOAD;
        end
      end
      LOAD: state_next = SEND;
      SEND: begin
        serial_send = 1'b1;
        state_next  = WAIT_BUSY;
      end
      // A transmitter that never raises busy is assumed to have taken the word.
      WAIT_BUSY: begin
        if (serial_busy) begin
          state_next = WAIT_DONE;
        end else if (ctr == CTR_W'(BUSY_TIMEOUT)) begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!serial_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      grant_q      <= '0;
      golden_nonce <= '0;
      golden_id    <= '0;
      ctr          <= '0;
      overflow     <= '0;
      drop_count   <= '0;
      pending      <= 1'b0;
    end else begin
      pending    <= |(~fifo_empty_next);
      overflow   <= overflow | drop_vec;
      drop_count <= drop_count_next;
      if (state == IDLE && state_next == LOAD) begin
        grant_q <= grant;
        rr_ptr  <= rr_next;
      end
      if (state == LOAD) begin
        golden_nonce <= fifo_head[grant_q];
        golden_id    <= grant_q;
      end
      if (state == SEND) begin
        ctr <= '0;
      end else if (state == WAIT_BUSY && !serial_busy) begin
        ctr <= ctr + CTR_W'(1);
      end
    end
  end

endmodule
